muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, replacing the fixed-width, multiply-only multiplier and its free-running HI/LO flops in the execute stage. It accepts one operation at a time via a start/busy handshake, supports signed and unsigned multiply and divide, and exposes `busy` to the hazard detector so that dependent instructions stall. Results land in HI/LO and are read through the existing out-select path.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits. Must be even and ≥ 8.
- `UNROLL`, 1: iteration steps per cycle. Must be 1, 2 or 4, and must divide `WIDTH`.
- `ITERS`: localparam, `WIDTH/UNROLL`.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request an operation; sampled only in IDLE.
- `op` in 2: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `a`, `b` in WIDTH: operands (rs, rt) already forwarded.
- `flush` in 1: cancel in-flight operation.
- `hi_we`, `lo_we` in 1: MTHI/MTLO write enables.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in progress; reset 0.
- `done` out 1: one-cycle pulse when HI/LO are updated by an operation; reset 0.
- `hi`, `lo` out WIDTH: architectural HI/LO; reset 0.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start=1` latches `op`, |a|, |b| (magnitudes taken only for signed ops), the result sign bits and `cnt=0`, then goes to CALC.
  - `start=0` stays in IDLE.
- CALC:
  - Performs `UNROLL` radix-2 steps per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - `cnt` increments each cycle; goes to FIX when `cnt==ITERS-1`.
- FIX:
  - Applies the sign correction.
  - Product is negated if `a`,`b` signs differ.
  - Quotient is negated if the signs differ; remainder takes the sign of `a`.
  - Writes HI/LO and asserts `done` at the next edge, then returns to IDLE.
- Result mapping:
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero: HI = a, LO = all ones, for both signed and unsigned. Latency is unchanged.
- Signed overflow (a = most-negative, b = −1): LO = most-negative, HI = 0.
- `start` while `busy` is ignored; the hazard unit must hold the instruction.
- `flush` in CALC/FIX returns the unit to IDLE at the next edge, with HI/LO unchanged and no `done`. `flush` in IDLE has priority over a simultaneous `start`, so the start is dropped.
- `hi_we`/`lo_we`:
  - Accepted only in IDLE; HI/LO update at the next edge.
  - Dropped while `busy`.
  - If asserted together with `start`, the write lands and the operation starts; the operation's result later overwrites HI/LO.
- `reset` mid-operation: the unit goes to IDLE immediately, with HI/LO = 0 and no `done`.

## Timing
- Start accepted at edge k:
  - `busy` = 1 from edge k through edge k+ITERS+1.
  - At edge k+ITERS+2, HI/LO are valid, `done` = 1 and `busy` = 0.
- Latency L = ITERS+2; for the defaults, 34 cycles.
- `busy` and `done` are registered outputs with no combinational path from inputs.
- A new start may be accepted in the same cycle that `done` is high.
- `hi`/`lo` are registered; reads in the `done` cycle see the new values.

## Structure
- Package `muldiv_pkg`:
  - `op_t` enum (MULT, MULTU, DIV, DIVU).
  - `state_t` enum (IDLE, CALC, FIX).
  - Helper function `is_signed(op)`.
- Sub-module `muldiv_step`:
  - Combinational, one radix-2 iteration for both mul and div, parametrised by `WIDTH`.
  - Instantiated `UNROLL` times in a chain.
- The FSM, counter, sign fixup and HI/LO registers live in `muldiv_unit`.

## Test plan
- MULT a=0xFFFF_FFFE (−2), b=3, WIDTH=32, UNROLL=1 -> `done` at start+34; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; `busy` high for exactly 34 cycles.
- MULTU a=0xFFFF_FFFF, b=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV a=−7, b=2 -> LO=0xFFFF_FFFD (−3), HI=0xFFFF_FFFF (−1). DIVU a=7, b=0 -> HI=7, LO=0xFFFF_FFFF.
- DIV a=0x8000_0000, b=0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- Start MULTU 5×6, assert `flush` at cycle 10 -> no `done`, HI/LO keep prior values, `busy`=0 next cycle. Assert `reset` mid-CALC -> HI=LO=0 immediately.
- UNROLL=4: MULTU 5×6 -> HI=0, LO=30, latency 10. MTLO 0x1234 while `busy` -> ignored. MTLO 0x1234 in IDLE -> LO=0x1234 at the next edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and helpers for the iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_signed(op_t op);
        return (op == MULT) || (op == DIV);
    endfunction

    function automatic logic is_div(op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/result bundle between the execute stage and muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    import muldiv_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational radix-2 iteration: shift-add multiply or
//               restoring shift-subtract divide on a {hi,lo} accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, hi_i} + ({1'b0, m_i} & {(WIDTH+1){lo_i[0]}});
        w_shift = {hi_i, lo_i[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, m_i});
        // When w_ge holds the true difference is below m_i, so modulo-2^W is exact.
        w_diff  = w_shift[WIDTH-1:0] - m_i;
        if (is_div_i) begin
            hi_o = w_ge ? w_diff : w_shift[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], w_ge};
        end else begin
            hi_o = w_sum[WIDTH:1];
            lo_o = {w_sum[0], lo_i[WIDTH-1:1]};
        end
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative signed/unsigned multiply/divide with HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int ITERS = WIDTH / UNROLL;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

    if ((WIDTH % 2) != 0 || WIDTH < 8 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)
        || (WIDTH % UNROLL) != 0) begin : g_bad_params
        $error("muldiv_unit: unsupported WIDTH/UNROLL combination");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fix_ph_q, fix_ph_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             bz_q, bz_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0]   w_hi [UNROLL+1];
    logic [WIDTH-1:0]   w_lo [UNROLL+1];
    logic               w_sgn;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_hi[0] = acc_hi_q;
    assign w_lo[0] = acc_lo_q;

    generate
        for (genvar i = 0; i < UNROLL; i++) begin : g_step
            muldiv_step #(.WIDTH(WIDTH)) u_step (
                .is_div_i (div_q),
                .hi_i     (w_hi[i]),
                .lo_i     (w_lo[i]),
                .m_i      (m_q),
                .hi_o     (w_hi[i+1]),
                .lo_o     (w_lo[i+1])
            );
        end
    endgenerate

    assign w_sgn      = is_signed(bus.op);
    assign w_abs_a    = (w_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_abs_b    = (w_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign w_prod_neg = -{acc_hi_q, acc_lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fix_ph_d = fix_ph_q;
        div_d    = div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bz_d     = bz_q;
        a_d      = a_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start && !bus.flush) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    fix_ph_d = 1'b0;
                    div_d    = is_div(bus.op);
                    neg_d    = w_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    rneg_d   = w_sgn && bus.a[WIDTH-1];
                    bz_d     = (bus.b == '0);
                    a_d      = bus.a;
                    acc_hi_d = '0;
                    acc_lo_d = w_abs_a;
                    m_d      = w_abs_b;
                end
            end
            CALC: begin
                acc_hi_d = w_hi[UNROLL];
                acc_lo_d = w_lo[UNROLL];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d  = FIX;
                    fix_ph_d = 1'b0;
                end
            end
            FIX: begin
                // First FIX cycle corrects the sign in place, second commits HI/LO.
                if (!fix_ph_q) begin
                    fix_ph_d = 1'b1;
                    if (div_q) begin
                        if (bz_q) begin
                            acc_hi_d = a_q;
                            acc_lo_d = '1;
                        end else begin
                            acc_hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
                            acc_lo_d = neg_q  ? -acc_lo_q : acc_lo_q;
                        end
                    end else if (neg_q) begin
                        {acc_hi_d, acc_lo_d} = w_prod_neg;
                    end
                end else begin
                    hi_d    = acc_hi_q;
                    lo_d    = acc_lo_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush && state_q != IDLE) begin
            state_d = IDLE;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fix_ph_q <= 1'b0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bz_q     <= 1'b0;
            done_q   <= 1'b0;
            a_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fix_ph_q <= fix_ph_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bz_q     <= bz_d;
            done_q   <= done_d;
            a_q      <= a_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench driving UNROLL=1 and UNROLL=4 units in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, flush, hi_we, lo_we;
    op_t         op;
    logic [31:0] a, b, wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus1 ();
    muldiv_if #(.WIDTH(32)) bus4 ();

    assign bus1.start = start;  assign bus4.start = start;
    assign bus1.op    = op;     assign bus4.op    = op;
    assign bus1.a     = a;      assign bus4.a     = a;
    assign bus1.b     = b;      assign bus4.b     = b;
    assign bus1.flush = flush;  assign bus4.flush = flush;
    assign bus1.hi_we = hi_we;  assign bus4.hi_we = hi_we;
    assign bus1.lo_we = lo_we;  assign bus4.lo_we = lo_we;
    assign bus1.wdata = wdata;  assign bus4.wdata = wdata;

    muldiv_unit #(.WIDTH(32), .UNROLL(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    muldiv_unit #(.WIDTH(32), .UNROLL(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, {HI,LO} packed into 64 bits.
    function automatic logic [63:0] model(input op_t o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [31:0] uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MULT:  return 64'(sx * sy);
            MULTU: return {32'b0, x} * {32'b0, y};
            DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = x / y;
                ur = x % y;
                return {ur, uq};
            end
        endcase
    endfunction

    task automatic do_op(input string tag, input op_t o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
        int lat1, lat4, bsy1, bsy4, dn1, dn4;
        logic [63:0] cap1, cap4;
        lat1 = -1; lat4 = -1; bsy1 = 0; bsy4 = 0; dn1 = 0; dn4 = 0;
        cap1 = '0; cap4 = '0;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus1.busy) bsy1++;
            if (bus4.busy) bsy4++;
            if (bus1.done) begin
                dn1++;
                if (lat1 < 0) begin lat1 = n; cap1 = {bus1.hi, bus1.lo}; end
            end
            if (bus4.done) begin
                dn4++;
                if (lat4 < 0) begin lat4 = n; cap4 = {bus4.hi, bus4.lo}; end
            end
            @(negedge clk);
        end
        check($sformatf("%s u1 result", tag), cap1, exp);
        check($sformatf("%s u1 latency", tag), 64'(lat1), 64'd34);
        check($sformatf("%s u1 busy cycles", tag), 64'(bsy1), 64'd34);
        check($sformatf("%s u1 done pulses", tag), 64'(dn1), 64'd1);
        check($sformatf("%s u4 result", tag), cap4, exp);
        check($sformatf("%s u4 latency", tag), 64'(lat4), 64'd10);
        check($sformatf("%s u4 busy cycles", tag), 64'(bsy4), 64'd10);
        check($sformatf("%s u4 done pulses", tag), 64'(dn4), 64'd1);
    endtask

    task automatic count_done(input string tag);
        int dn;
        dn = 0;
        for (int n = 0; n < 40; n++) begin
            if (bus1.done || bus4.done) dn++;
            @(negedge clk);
        end
        check($sformatf("%s no done", tag), 64'(dn), 64'd0);
    endtask

    initial begin
        int          sel;
        int          bsy;
        op_t         ro;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = MULT; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", {62'b0, bus1.busy, bus4.busy}, 64'd0);
        check("reset done", {62'b0, bus1.done, bus4.done}, 64'd0);
        check("reset u1 hilo", {bus1.hi, bus1.lo}, 64'd0);
        check("reset u4 hilo", {bus4.hi, bus4.lo}, 64'd0);

        vecs[0] = '{MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF};
        vecs[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{MULTU, 32'd5,         32'd6,        32'd0,         32'd30};
        vecs[6] = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{DIV,   32'hFFFF_FFF8, 32'd0,        32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[8] = '{DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
        vecs[9] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

        for (int i = 0; i < 20; i++) begin
            ro  = op_t'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) rb = 32'hFFFF_FFFF;
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            do_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
        end

        // MTLO / MTHI in IDLE
        @(negedge clk); lo_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); lo_we = 1'b0;
        check("mtlo idle u1", 64'(bus1.lo), 64'h1234);
        check("mtlo idle u4", 64'(bus4.lo), 64'h1234);
        hi_we = 1'b1; wdata = 32'h5678;
        @(negedge clk); hi_we = 1'b0;
        check("mthi idle u1", 64'(bus1.hi), 64'h5678);

        // MTLO while busy is dropped, then flush cancels the operation
        start = 1'b1; op = MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        lo_we = 1'b1; wdata = 32'hDEAD;
        @(negedge clk); lo_we = 1'b0;
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush busy", {62'b0, bus1.busy, bus4.busy}, 64'd0);
        count_done("flush");
        check("flush u1 hilo", {bus1.hi, bus1.lo}, {32'h5678, 32'h1234});
        check("flush u4 hilo", {bus4.hi, bus4.lo}, {32'h5678, 32'h1234});

        // flush in IDLE drops a simultaneous start
        start = 1'b1; flush = 1'b1;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        check("idle flush busy", {62'b0, bus1.busy, bus4.busy}, 64'd0);
        count_done("idle flush");

        // MTHI with start: write lands, operation result overwrites later
        start = 1'b1; hi_we = 1'b1; wdata = 32'hABCD; op = MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk); start = 1'b0; hi_we = 1'b0;
        check("mthi+start hi", {bus1.hi, bus4.hi}, {32'hABCD, 32'hABCD});
        check("mthi+start busy", {62'b0, bus1.busy, bus4.busy}, 64'd3);
        repeat (40) @(negedge clk);
        check("mthi+start u1 result", {bus1.hi, bus1.lo}, 64'd30);
        check("mthi+start u4 result", {bus4.hi, bus4.lo}, 64'd30);

        // New start accepted in the cycle done is high
        start = 1'b1; op = MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk); start = 1'b0;
        bsy = 0;
        while (!bus1.done && bsy < 60) begin
            @(negedge clk);
            bsy++;
        end
        check("b2b first done seen", 64'(bus1.done), 64'd1);
        start = 1'b1; a = 32'd7; b = 32'd8;
        @(negedge clk); start = 1'b0;
        check("b2b accepted", 64'(bus1.busy), 64'd1);
        repeat (40) @(negedge clk);
        check("b2b u1 result", {bus1.hi, bus1.lo}, 64'd56);
        check("b2b u4 result", {bus4.hi, bus4.lo}, 64'd56);

        // Asynchronous reset mid-CALC
        start = 1'b1; op = MULTU; a = 32'd5; b = 32'd6;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset u1 hilo", {bus1.hi, bus1.lo}, 64'd0);
        check("async reset u4 hilo", {bus4.hi, bus4.lo}, 64'd0);
        check("async reset busy", {62'b0, bus1.busy, bus4.busy}, 64'd0);
        @(negedge clk); reset = 1'b0;
        count_done("after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
